// File: rtl/cordic_engine.sv
// Iterative BAM CORDIC (rotation: sin/cos/rotate, vectoring: magnitude/atan2) with quadrant fold, gain fix and clamp.
// Latency ITERATIONS+1+GAIN_COMP edges from accept; one op in flight, result held until out_ready.
module cordic_engine #(
    parameter int WIDTH       = 16,
    parameter int ANGLE_WIDTH = 32,
    parameter int ITERATIONS  = 15,
    parameter int GAIN_COMP   = 1
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic                   i_in_mode,
    input  logic [WIDTH-1:0]       i_x_in,
    input  logic [WIDTH-1:0]       i_y_in,
    input  logic [ANGLE_WIDTH-1:0] i_z_in,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [WIDTH-1:0]       o_x_out,
    output logic [WIDTH-1:0]       o_y_out,
    output logic [ANGLE_WIDTH-1:0] o_z_out,
    output logic                   o_out_mode,
    output logic                   o_sat
);
    localparam int XW      = WIDTH + 2;
    localparam int PW      = XW + 17;
    localparam int ATAN_SH = 32 - ANGLE_WIDTH;
    localparam logic [32:0] ATAN_RND = (33'd1 << ATAN_SH) >> 1;
    localparam logic [ANGLE_WIDTH-1:0] HALF = {1'b1, {(ANGLE_WIDTH-1){1'b0}}};
    localparam logic signed [PW-1:0] K_GAIN = PW'(16'h4DBA);
    localparam logic signed [PW-1:0] K_RND  = PW'(32'd16384);
    localparam logic signed [XW-1:0] MAXV = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [XW-1:0] MINV = {3'b111, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_PREROT, S_ITER, S_SCALE, S_DONE} state_t;

    state_t                   r_state, w_next;
    logic signed [XW-1:0]     r_x, r_y;
    logic [ANGLE_WIDTH-1:0]   r_z;
    logic                     r_mode;
    logic [4:0]               r_iter;
    logic                     r_in_ready;

    logic                     w_accept, w_last, w_dpos;
    logic signed [XW-1:0]     w_xs, w_ys, w_x_nxt, w_y_nxt, w_x_sc, w_y_sc;
    logic [ANGLE_WIDTH-1:0]   w_atan, w_z_nxt;
    logic [32:0]              w_atan_ext;
    logic signed [PW-1:0]     w_px, w_py;
    logic                     w_sat_x, w_sat_y;

    function automatic logic [31:0] atan_rom(input logic [4:0] idx);
        case (idx)
            5'd0:  atan_rom = 32'h20000000;
            5'd1:  atan_rom = 32'h12E4051E;
            5'd2:  atan_rom = 32'h09FB385B;
            5'd3:  atan_rom = 32'h051111D4;
            5'd4:  atan_rom = 32'h028B0D43;
            5'd5:  atan_rom = 32'h0145D7E1;
            5'd6:  atan_rom = 32'h00A2F61E;
            5'd7:  atan_rom = 32'h00517C55;
            5'd8:  atan_rom = 32'h0028BE53;
            5'd9:  atan_rom = 32'h00145F2F;
            5'd10: atan_rom = 32'h000A2F98;
            5'd11: atan_rom = 32'h000517CC;
            5'd12: atan_rom = 32'h00028BE6;
            5'd13: atan_rom = 32'h000145F3;
            5'd14: atan_rom = 32'h0000A2FA;
            5'd15: atan_rom = 32'h0000517D;
            5'd16: atan_rom = 32'h000028BE;
            5'd17: atan_rom = 32'h0000145F;
            5'd18: atan_rom = 32'h00000A30;
            5'd19: atan_rom = 32'h00000518;
            5'd20: atan_rom = 32'h0000028C;
            5'd21: atan_rom = 32'h00000146;
            5'd22: atan_rom = 32'h000000A3;
            5'd23: atan_rom = 32'h00000051;
            default: atan_rom = 32'h00000000;
        endcase
    endfunction

    // Returns {clamped, value}
    function automatic logic [WIDTH:0] clamp(input logic signed [XW-1:0] v);
        if (v > MAXV)
            clamp = {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
        else if (v < MINV)
            clamp = {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
        else
            clamp = {1'b0, v[WIDTH-1:0]};
    endfunction

    always_ff @(posedge i_clock) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_PREROT;
            S_PREROT: w_next = S_ITER;
            S_ITER:   if (w_last) w_next = (GAIN_COMP != 0) ? S_SCALE : S_DONE;
            S_SCALE:  w_next = S_DONE;
            S_DONE:   if (i_out_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_in_ready  = r_in_ready;
        o_out_valid = (r_state == S_DONE);
        w_accept    = (r_state == S_IDLE) && r_in_ready && i_in_valid;
        w_last      = (r_iter == 5'(ITERATIONS - 1));
    end

    // in_ready is registered so it stays low through the reset-release cycle
    always_ff @(posedge i_clock) begin
        if (i_reset)
            r_in_ready <= 1'b0;
        else
            r_in_ready <= (w_next == S_IDLE);
    end

    always_comb begin
        w_xs       = r_x >>> r_iter;
        w_ys       = r_y >>> r_iter;
        w_atan_ext = {1'b0, atan_rom(r_iter)} + ATAN_RND;
        w_atan     = ANGLE_WIDTH'(w_atan_ext >> ATAN_SH);
        w_dpos     = r_mode ? r_y[XW-1] : ~r_z[ANGLE_WIDTH-1];
        w_x_nxt    = w_dpos ? (r_x - w_ys) : (r_x + w_ys);
        w_y_nxt    = w_dpos ? (r_y + w_xs) : (r_y - w_xs);
        w_z_nxt    = w_dpos ? (r_z - w_atan) : (r_z + w_atan);
        w_px       = PW'(r_x) * K_GAIN;
        w_py       = PW'(r_y) * K_GAIN;
        w_x_sc     = XW'((w_px + K_RND) >>> 15);
        w_y_sc     = XW'((w_py + K_RND) >>> 15);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_x    <= '0;
            r_y    <= '0;
            r_z    <= '0;
            r_mode <= 1'b0;
            r_iter <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_x    <= {{2{i_x_in[WIDTH-1]}}, i_x_in};
                    r_y    <= {{2{i_y_in[WIDTH-1]}}, i_y_in};
                    r_z    <= i_z_in;
                    r_mode <= i_in_mode;
                end
                S_PREROT: begin
                    r_iter <= '0;
                    if (r_mode) begin
                        r_z <= r_x[XW-1] ? HALF : '0;
                        if (r_x[XW-1]) begin
                            r_x <= -r_x;
                            r_y <= -r_y;
                        end
                    end else if (r_z[ANGLE_WIDTH-1] ^ r_z[ANGLE_WIDTH-2]) begin
                        r_x <= -r_x;
                        r_y <= -r_y;
                        r_z <= r_z + HALF;
                    end
                end
                S_ITER: begin
                    r_x    <= w_x_nxt;
                    r_y    <= w_y_nxt;
                    r_z    <= w_z_nxt;
                    r_iter <= r_iter + 5'd1;
                end
                S_SCALE: begin
                    r_x <= w_x_sc;
                    r_y <= w_y_sc;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        {w_sat_x, o_x_out} = clamp(r_x);
        {w_sat_y, o_y_out} = clamp(r_y);
        o_sat      = w_sat_x | w_sat_y;
        o_z_out    = r_z;
        o_out_mode = r_mode;
    end
endmodule

// File: tb/tb_cordic_engine.sv
// Directed bench for cordic_engine: one gain-compensated and one uncompensated instance.
module tb_cordic_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, vld_gc, vld_ng, mode, ordy;
    logic [15:0] xi, yi;
    logic [31:0] zi;
    logic        gc_rdy, gc_ov, gc_mode, gc_sat;
    logic        ng_rdy, ng_ov, ng_mode, ng_sat;
    logic [15:0] gc_x, gc_y, ng_x, ng_y;
    logic [31:0] gc_z, ng_z;

    int checks = 0;
    int errors = 0;

    cordic_engine #(.WIDTH(16), .ANGLE_WIDTH(32), .ITERATIONS(15), .GAIN_COMP(1)) u_gc (
        .i_clock(clk), .i_reset(rst), .i_in_valid(vld_gc), .o_in_ready(gc_rdy),
        .i_in_mode(mode), .i_x_in(xi), .i_y_in(yi), .i_z_in(zi),
        .o_out_valid(gc_ov), .i_out_ready(ordy), .o_x_out(gc_x), .o_y_out(gc_y),
        .o_z_out(gc_z), .o_out_mode(gc_mode), .o_sat(gc_sat));

    cordic_engine #(.WIDTH(16), .ANGLE_WIDTH(32), .ITERATIONS(15), .GAIN_COMP(0)) u_ng (
        .i_clock(clk), .i_reset(rst), .i_in_valid(vld_ng), .o_in_ready(ng_rdy),
        .i_in_mode(mode), .i_x_in(xi), .i_y_in(yi), .i_z_in(zi),
        .o_out_valid(ng_ov), .i_out_ready(ordy), .o_x_out(ng_x), .o_y_out(ng_y),
        .o_z_out(ng_z), .o_out_mode(ng_mode), .o_sat(ng_sat));

    function automatic logic [31:0] sx(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input logic [31:0] obs, input logic [31:0] exp, input int tol);
        logic [31:0] d;
        int          ad;
        d  = obs - exp;
        ad = $signed(d);
        if (ad < 0) ad = -ad;
        checks++;
        assert ((ad <= tol) === 1'b1) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h tol=%0d", tag, obs, exp, tol);
        end
    endtask

    // Issue one op to the selected instance; returns once out_valid is seen (or budget expires)
    task automatic run_op(input bit sel, input bit m, input logic [15:0] x, input logic [15:0] y,
                          input logic [31:0] z, input int exp_lat);
        int n;
        int lat;
        mode = m; xi = x; yi = y; zi = z;
        if (sel) vld_ng = 1'b1; else vld_gc = 1'b1;
        n = 0;
        while (!(sel ? ng_rdy : gc_rdy) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_ready", 32'(sel ? ng_rdy : gc_rdy), 32'd1);
        @(posedge clk); #1;
        vld_gc = 1'b0; vld_ng = 1'b0;
        chk("busy_after_accept", 32'(sel ? ng_rdy : gc_rdy), 32'd0);
        lat = 0;
        while (!(sel ? ng_ov : gc_ov) && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
    endtask

    task automatic finish_op(input bit sel);
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
        chk("ready_after_handshake", 32'(sel ? ng_rdy : gc_rdy), 32'd1);
        chk("valid_after_handshake", 32'(sel ? ng_ov : gc_ov), 32'd0);
    endtask

    initial begin
        rst = 1'b1; vld_gc = 1'b0; vld_ng = 1'b0; mode = 1'b0; ordy = 1'b0;
        xi = '0; yi = '0; zi = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(gc_rdy), 32'd0);
        chk("rst_out_valid", 32'(gc_ov), 32'd0);
        chk("rst_x", sx(gc_x), 32'd0);
        chk("rst_z", gc_z, 32'd0);
        chk("rst_sat", 32'(gc_sat), 32'd0);
        chk("rst_ng_ready", 32'(ng_rdy), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", 32'(gc_rdy), 32'd1);
        chk("ready_after_rst_ng", 32'(ng_rdy), 32'd1);

        // 45 degrees
        run_op(1'b0, 1'b0, 16'h4000, 16'h0000, 32'h2000_0000, 17);
        chk_near("rot45_x", sx(gc_x), 32'h0000_2D41, 4);
        chk_near("rot45_y", sx(gc_y), 32'h0000_2D41, 4);
        chk_near("rot45_z", gc_z, 32'h0, 32'h10000);
        chk("rot45_sat", 32'(gc_sat), 32'd0);
        chk("rot45_mode", 32'(gc_mode), 32'd0);
        finish_op(1'b0);

        // 225 degrees: folded by the quadrant pre-rotation
        run_op(1'b0, 1'b0, 16'h4000, 16'h0000, 32'hA000_0000, 17);
        chk_near("rot225_x", sx(gc_x), 32'hFFFF_D2BF, 4);
        chk_near("rot225_y", sx(gc_y), 32'hFFFF_D2BF, 4);
        finish_op(1'b0);

        // -45 degrees
        run_op(1'b0, 1'b0, 16'h4000, 16'h0000, 32'hE000_0000, 17);
        chk_near("rotm45_x", sx(gc_x), 32'h0000_2D41, 4);
        chk_near("rotm45_y", sx(gc_y), 32'hFFFF_D2BF, 4);
        finish_op(1'b0);

        // Vectoring (-0.5, -0.5): angle 225 degrees, magnitude 0.7071
        run_op(1'b0, 1'b1, 16'hE000, 16'hE000, 32'h1234_5678, 17);
        chk_near("vec_z", gc_z, 32'hA000_0000, 32'h0008_0000);
        chk_near("vec_x", sx(gc_x), 32'h0000_2D41, 4);
        chk_near("vec_y", sx(gc_y), 32'h0, 4);
        chk("vec_mode", 32'(gc_mode), 32'd1);
        finish_op(1'b0);

        // Uncompensated gain saturates a near-full-scale vector
        run_op(1'b1, 1'b0, 16'h7FFF, 16'h7FFF, 32'h0, 16);
        chk("sat_x", sx(ng_x), 32'h0000_7FFF);
        chk("sat_y", sx(ng_y), 32'h0000_7FFF);
        chk("sat_flag", 32'(ng_sat), 32'd1);
        finish_op(1'b1);
        run_op(1'b1, 1'b0, 16'h4000, 16'h0000, 32'h0, 16);
        chk_near("nosat_x", sx(ng_x), 32'd26981, 4);
        chk_near("nosat_y", sx(ng_y), 32'h0, 4);
        chk("nosat_flag", 32'(ng_sat), 32'd0);
        finish_op(1'b1);

        // Backpressure with in_valid pulses that must be ignored
        run_op(1'b0, 1'b0, 16'h4000, 16'h0000, 32'h2000_0000, 17);
        for (int k = 0; k < 10; k++) begin
            vld_gc = (k % 2 == 0);
            xi = 16'h1111;
            @(posedge clk); #1;
            chk("bp_valid", 32'(gc_ov), 32'd1);
            chk("bp_ready", 32'(gc_rdy), 32'd0);
            chk_near("bp_x", sx(gc_x), 32'h0000_2D41, 4);
        end
        vld_gc = 1'b0;
        finish_op(1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_no_phantom", 32'(gc_ov), 32'd0);

        // Reset while iterating (i = 5)
        mode = 1'b0; xi = 16'h4000; yi = 16'h0000; zi = 32'h2000_0000;
        vld_gc = 1'b1;
        @(posedge clk); #1;
        vld_gc = 1'b0;
        chk("rstmid_busy", 32'(gc_rdy), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_valid", 32'(gc_ov), 32'd0);
        chk("rstmid_x", sx(gc_x), 32'd0);
        chk("rstmid_y", sx(gc_y), 32'd0);
        chk("rstmid_z", gc_z, 32'd0);
        chk("rstmid_ready", 32'(gc_rdy), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_ready_after", 32'(gc_rdy), 32'd1);
        run_op(1'b0, 1'b0, 16'h4000, 16'h0000, 32'h2000_0000, 17);
        chk_near("post_rst_x", sx(gc_x), 32'h0000_2D41, 4);
        chk_near("post_rst_y", sx(gc_y), 32'h0000_2D41, 4);
        finish_op(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cordic_engine.md
# cordic_engine

Parameterised iterative CORDIC engine supporting both rotation mode (sin/cos, vector rotate) and vectoring mode (magnitude/atan2). Angles use binary angle measurement, so full-circle wrap-around comes free. The block adds quadrant pre-rotation, optional gain compensation, output saturation and valid/ready handshakes on both sides. It sits between DSP datapath stages as the shared trig/polar-conversion resource.

## Interface
- `WIDTH`, 16: signed coordinate width, Q2.(WIDTH-2); supported range 8..24.
- `ANGLE_WIDTH`, 32: signed angle width; full turn = 2^ANGLE_WIDTH (BAM); supported range 16..32.
- `ITERATIONS`, 15: micro-rotations; supported range 8..24.
- `GAIN_COMP`, 1: when 1, scale results by K ≈ 0.6072529350 (constant 0x4DBA, Q1.15); when 0, results carry gain 1/K ≈ 1.6468.

- `clock`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  engine can accept.
- `in_mode`  in  1  0 = rotation, 1 = vectoring.
- `x_in`, `y_in`  in  WIDTH  signed start vector.
- `z_in`  in  ANGLE_WIDTH  rotation angle (BAM); ignored in vectoring.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts.
- `x_out`, `y_out`  out  WIDTH  saturated result vector.
- `z_out`  out  ANGLE_WIDTH  residual angle (rotation) or atan2(y,x) (vectoring).
- `out_mode`  out  1  echo of captured in_mode.
- `sat`  out  1  x_out or y_out clamped for this result.

## Operation
- FSM states: IDLE → PREROT → ITER → (SCALE if GAIN_COMP) → DONE → IDLE.
- IDLE: `in_ready`=1. Accept on `in_valid`&`in_ready`. Capture x, y, z and mode into internal registers sign-extended to WIDTH+2 bits. Inputs are ignored after capture.
- PREROT (one cycle):
  - Rotation: if z's top two bits are 01 or 10 (|angle| ≥ 90°), negate x and y and add a half turn (0x8000_0000 at ANGLE_WIDTH=32) to z, modulo 2^ANGLE_WIDTH.
  - Vectoring: z=0. If x<0, negate x and y and set z = half turn.
- ITER: counter i runs 0..ITERATIONS-1.
  - d = sign(z) in rotation; d = -sign(y) in vectoring; zero counts as positive.
  - x' = x − d·(y>>>i), y' = y + d·(x>>>i), z' = z − d·atan_i.
- atan table: 32-bit ROM of round(atan(2^-i)/2π·2^32), i=0..23. Use an arithmetic right shift by 32−ANGLE_WIDTH with round-half-up.
- SCALE (GAIN_COMP=1 only): x,y ← (x·0x4DBA + 2^14) >>> 15.
- DONE:
  - Clamp x and y to [−2^(WIDTH-1), 2^(WIDTH-1)−1]. `sat`=1 if either coordinate clamped.
  - z is reported unchanged; it wraps modulo 2^ANGLE_WIDTH and never saturates.
  - Hold `out_valid`=1 with all outputs stable until `out_ready`. Then go to IDLE.
- One operation in flight; no overlap of input and output handshakes.

## Timing
- Reset (takes effect at the next edge, in any state): state=IDLE; `in_ready`, `out_valid`, `sat`, `out_mode`=0; `x_out`, `y_out`, `z_out`=0. `in_ready` is 1 from the first cycle after reset deasserts.
- Reset mid-operation aborts the operation; no result is ever produced for it.
- Latency: `out_valid` rises ITERATIONS+1+GAIN_COMP edges after the accepting edge (16 edges at defaults with GAIN_COMP=0, 17 edges with GAIN_COMP=1).
- `in_ready` is 0 from the accepting edge until the output handshake edge. It returns to 1 on the cycle after `out_valid`&`out_ready`.
- Minimum initiation interval: ITERATIONS+3+GAIN_COMP cycles with `out_ready` tied high.
- `in_valid` asserted while `in_ready`=0 is ignored, with no side effect.

## Test plan
- Rotation, defaults (GAIN_COMP=1): x=0x4000, y=0, z=0x2000_0000 (45°) → x_out, y_out = 0x2D41 ±4 LSB; `sat`=0; `out_valid` exactly 17 edges after accept.
- Wrap-around: z=0xA000_0000 (225°) and z=0xE000_0000 (−45°), x=0x4000 → (−0x2D41, −0x2D41) and (0x2D41, −0x2D41), each ±4 LSB.
- Vectoring: x=−0x2000, y=−0x2000 → z_out = 0xA000_0000 ±2^19, x_out = 0x2D41 ±4, |y_out| ≤ 4, out_mode=1.
- Saturation, GAIN_COMP=0: x=y=0x7FFF, z=0 → x_out = y_out = 0x7FFF, `sat`=1. The next op, x=0x4000, y=0, z=0, → `sat`=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises, pulsing in_valid meanwhile. Outputs stay stable, in_ready=0 and the pulses are ignored. After the out_ready pulse, in_ready=1 next cycle.
- Reset during ITER (i=5): next cycle out_valid=0 and all outputs 0. After reset release, in_ready=1 and a fresh 45° op returns the correct result.
